set_assoc_cache_ctrl: RTL and testbench

Parametrised set-associative cache with a built-in miss/write controller. It generalises the fixed 2-set, 8-way FIFO-replacement cache in set count, way count, line size and address width. It adds a request/done CPU handshake, a line-refill handshake to memory, write-through/no-allocate stores and a flush. It sits between the CPU data port and the main-memory block interface.

---
 rtl/set_assoc_cache_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_set_assoc_cache_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache_ctrl.sv
// Set-associative cache with FIFO replacement, write-through/no-allocate stores and a flush.
// Latency: load hit 2 edges; load miss 3 edges plus memory wait; store 2 edges plus memory wait.
// Backpressure: cpu_ready is high only in IDLE without flush; mem_req is held until mem_ack.
module set_assoc_cache_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int WORDS_PER_LINE = 16,
  parameter int NUM_SETS       = 2,
  parameter int NUM_WAYS       = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [31:0]                 cpu_wdata,
  input  logic                        cpu_flush,
  output logic                        cpu_ready,
  output logic                        cpu_done,
  output logic                        cpu_hit,
  output logic [31:0]                 cpu_rdata,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [31:0]                 mem_wdata,
  input  logic                        mem_ack,
  input  logic [32*WORDS_PER_LINE-1:0] mem_rdata
);

  localparam int LW     = 32 * WORDS_PER_LINE;
  localparam int WSEL_W = $clog2(WORDS_PER_LINE);
  localparam int OFF    = WSEL_W + 2;
  localparam int IDX    = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_W - OFF - IDX;
  localparam int WAY_W  = $clog2(NUM_WAYS);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] REFILL = 2'd2;
  localparam logic [1:0] WRMEM  = 2'd3;

  logic [1:0]          state;
  logic [ADDR_W-3:0]   addrQ;   // word address of the accepted request
  logic                weQ;
  logic [31:0]         wdataQ;
  logic                missQ;   // load missed at least once; final done reports a miss
  logic                hitQ;    // store lookup result, reported on the write ack

  logic [NUM_WAYS-1:0] validQ [NUM_SETS];
  logic [WAY_W-1:0]    ptrQ   [NUM_SETS];
  logic [TAG_W-1:0]    tagQ   [NUM_SETS][NUM_WAYS];
  logic [LW-1:0]       dataQ  [NUM_SETS][NUM_WAYS];

  logic [TAG_W-1:0]    reqTag;
  logic [IDX-1:0]      reqIdx;
  logic [WSEL_W-1:0]   reqWord;
  logic                hit;
  logic [WAY_W-1:0]    hitWay;
  logic [WAY_W-1:0]    victim;
  logic                allValid;
  logic [31:0]         hitWord;
  logic                memAccept;
  logic [1:0]          unusedAddrBits;

  // Byte lane bits never matter: every access is a full word.
  assign unusedAddrBits = cpu_addr[1:0];

  assign reqTag    = addrQ[ADDR_W-3 -: TAG_W];
  assign reqIdx    = addrQ[OFF+IDX-3 -: IDX];
  assign reqWord   = addrQ[WSEL_W-1:0];
  assign hitWord   = dataQ[reqIdx][hitWay][{reqWord, 5'b0} +: 32];
  assign memAccept = mem_req && mem_ack;
  assign cpu_ready = (state == IDLE) && !cpu_flush;

  // Tag match across the indexed set; at most one valid way can carry a given tag.
  always_comb begin
    hit    = 1'b0;
    hitWay = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (validQ[reqIdx][w] && (tagQ[reqIdx][w] == reqTag)) begin
        hit    = 1'b1;
        hitWay = WAY_W'(w);
      end
    end
  end

  // Victim choice: lowest invalid way first, otherwise the set's FIFO pointer.
  always_comb begin
    allValid = &validQ[reqIdx];
    victim   = ptrQ[reqIdx];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!validQ[reqIdx][w]) victim = WAY_W'(w);
    end
  end

  // Controller state, valid bits, FIFO pointers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addrQ     <= '0;
      weQ       <= 1'b0;
      wdataQ    <= '0;
      missQ     <= 1'b0;
      hitQ      <= 1'b0;
      cpu_done  <= 1'b0;
      cpu_hit   <= 1'b0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        validQ[s] <= '0;
        ptrQ[s]   <= '0;
      end
    end else begin
      cpu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_flush) begin
            for (int s = 0; s < NUM_SETS; s++) begin
              validQ[s] <= '0;
              ptrQ[s]   <= '0;
            end
          end else if (cpu_req) begin
            addrQ  <= cpu_addr[ADDR_W-1:2];
            weQ    <= cpu_we;
            wdataQ <= cpu_wdata;
            missQ  <= 1'b0;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!weQ && hit) begin
            cpu_done  <= 1'b1;
            cpu_hit   <= !missQ;
            cpu_rdata <= hitWord;
            state     <= IDLE;
          end else if (!weQ) begin
            missQ    <= 1'b1;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {reqTag, reqIdx, {OFF{1'b0}}};
            state    <= REFILL;
          end else begin
            hitQ      <= hit;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {addrQ, 2'b00};
            mem_wdata <= wdataQ;
            state     <= WRMEM;
          end
        end
        REFILL: begin
          if (memAccept) begin
            mem_req                <= 1'b0;
            validQ[reqIdx][victim] <= 1'b1;
            if (allValid) ptrQ[reqIdx] <= ptrQ[reqIdx] + WAY_W'(1);
            state                  <= LOOKUP;
          end
        end
        WRMEM: begin
          if (memAccept) begin
            mem_req  <= 1'b0;
            cpu_done <= 1'b1;
            cpu_hit  <= hitQ;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage: refill writes a whole line and tag, a store hit patches one word.
  always_ff @(posedge clk) begin
    if ((state == REFILL) && memAccept) begin
      dataQ[reqIdx][victim] <= mem_rdata;
      tagQ[reqIdx][victim]  <= reqTag;
    end else if ((state == LOOKUP) && weQ && hit) begin
      dataQ[reqIdx][hitWay][{reqWord, 5'b0} +: 32] <= wdataQ;
    end
  end

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed test of set_assoc_cache_ctrl with default parameters.
// Each access is stepped edge by edge with exact expected timing.
// Memory acks arrive three cycles after mem_req rises.
module tb_set_assoc_cache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_flush;
  logic         cpu_ready;
  logic         cpu_done;
  logic         cpu_hit;
  logic [31:0]  cpu_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ack;
  logic [511:0] mem_rdata;

  int           total = 0;
  int           bad   = 0;
  logic [31:0]  curAddr = '0;

  set_assoc_cache_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_flush (cpu_flush),
    .cpu_ready (cpu_ready),
    .cpu_done  (cpu_done),
    .cpu_hit   (cpu_hit),
    .cpu_rdata (cpu_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s addr=%h observed=%h expected=%h", tag, curAddr, obs, exp);
    end
  endtask

  function automatic logic [511:0] mkLine(input logic [31:0] base);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  // One CPU access; refills return word i = lineBase + i.
  task automatic access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic expHit, input logic [31:0] expRdata, input logic [31:0] lineBase);
    logic        memTxn;
    logic [31:0] expMemAddr;
    memTxn     = we || !expHit;
    expMemAddr = we ? {addr[31:2], 2'b00} : {addr[31:6], 6'b0};
    curAddr    = addr;
    check("ready_before", 32'(cpu_ready), 32'd1);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    step();
    cpu_req = 1'b0;
    check("busy_after_accept", 32'(cpu_ready), 32'd0);
    step();
    if (!memTxn) begin
      check("hit_done", 32'(cpu_done), 32'd1);
      check("hit_flag", 32'(cpu_hit), 32'd1);
      check("hit_rdata", cpu_rdata, expRdata);
      check("hit_no_memreq", 32'(mem_req), 32'd0);
    end else begin
      check("memreq_rise", 32'(mem_req), 32'd1);
      check("mem_we", 32'(mem_we), 32'(we));
      check("mem_addr", mem_addr, expMemAddr);
      if (we) check("mem_wdata", mem_wdata, wdata);
      check("no_early_done", 32'(cpu_done), 32'd0);
      step();
      step();
      check("memreq_hold", 32'(mem_req), 32'd1);
      mem_ack   = 1'b1;
      mem_rdata = mkLine(lineBase);
      step();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      check("memreq_drop", 32'(mem_req), 32'd0);
      if (!we) begin
        check("refill_no_done_yet", 32'(cpu_done), 32'd0);
        step();
      end
      check("miss_done", 32'(cpu_done), 32'd1);
      check("miss_hitflag", 32'(cpu_hit), 32'(expHit));
      if (!we) check("miss_rdata", cpu_rdata, expRdata);
    end
    step();
    check("done_pulse", 32'(cpu_done), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_flush = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    step();
    step();
    check("rst_done", 32'(cpu_done), 32'd0);
    check("rst_hit", 32'(cpu_hit), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_memreq", 32'(mem_req), 32'd0);
    check("rst_memwe", 32'(mem_we), 32'd0);
    check("rst_memaddr", mem_addr, 32'd0);
    check("rst_memwdata", mem_wdata, 32'd0);
    reset = 1'b1;
    step();
    check("rst_ready", 32'(cpu_ready), 32'd1);

    // Stray ack with no request outstanding does nothing.
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("stray_ack_done", 32'(cpu_done), 32'd0);
    check("stray_ack_req", 32'(mem_req), 32'd0);

    // Cold load then a hit in the same line.
    access(32'h40, 1'b0, 32'h0, 1'b0, 32'd0, 32'd0);
    access(32'h44, 1'b0, 32'h0, 1'b1, 32'd1, 32'd0);

    // Fill set 0 (tags 0..7), ninth line evicts way 0 and moves the pointer to 1.
    for (int k = 0; k < 9; k++)
      access(32'(k) * 32'h80, 1'b0, 32'h0, 1'b0, 32'(k) * 32'h100, 32'(k) * 32'h100);
    access(32'h080, 1'b0, 32'h0, 1'b1, 32'h100, 32'h0);
    access(32'h000, 1'b0, 32'h0, 1'b0, 32'hA00, 32'hA00);  // evicts 0x080 (way 1)
    access(32'h080, 1'b0, 32'h0, 1'b0, 32'hB00, 32'hB00);  // evicts 0x100 (way 2)
    access(32'h400, 1'b0, 32'h0, 1'b1, 32'h800, 32'h0);

    // Store hit updates the line and writes through.
    access(32'h44, 1'b1, 32'hDEADBEEF, 1'b1, 32'h0, 32'h0);
    access(32'h44, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 32'h0);

    // Store miss: no allocation, so the following load misses.
    access(32'h1000, 1'b1, 32'h12345678, 1'b0, 32'h0, 32'h0);
    access(32'h1000, 1'b0, 32'h0, 1'b0, 32'h500, 32'h500);

    // Flush with a concurrent request: flush wins, request is dropped.
    curAddr   = 32'h44;
    cpu_flush = 1'b1;
    cpu_req   = 1'b1;
    cpu_addr  = 32'h44;
    cpu_we    = 1'b0;
    #1;
    check("flush_ready_low", 32'(cpu_ready), 32'd0);
    step();
    cpu_flush = 1'b0;
    cpu_req   = 1'b0;
    check("flush_no_done", 32'(cpu_done), 32'd0);
    step();
    check("flush_req_dropped", 32'(mem_req), 32'd0);
    check("flush_req_dropped_done", 32'(cpu_done), 32'd0);
    access(32'h44, 1'b0, 32'h0, 1'b0, 32'd1, 32'd0);
    access(32'h400, 1'b0, 32'h0, 1'b0, 32'h900, 32'h900);

    // Reset while a refill is outstanding.
    curAddr  = 32'h800;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h800;
    step();
    cpu_req = 1'b0;
    step();
    check("midrst_memreq_up", 32'(mem_req), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_memreq_async", 32'(mem_req), 32'd0);
    step();
    check("midrst_no_done", 32'(cpu_done), 32'd0);
    reset = 1'b1;
    check("midrst_ready", 32'(cpu_ready), 32'd1);
    step();
    check("midrst_idle_done", 32'(cpu_done), 32'd0);
    check("midrst_idle_req", 32'(mem_req), 32'd0);
    access(32'h40, 1'b0, 32'h0, 1'b0, 32'h300, 32'h300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
